// File: rtl/regbus_pkg.sv
// Shared types and widths for the register-file read-bus arbiter.
// Counter widths cover the full legal ranges: TURN_CYCLES up to 7, MAX_HOLD up to 255.
package regbus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  localparam int NREQ_MAX    = 32;
  localparam int OWNER_W_MAX = 5;
  localparam int TURN_CNT_W  = 3;
  localparam int HOLD_CNT_W  = 8;

  function automatic int owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regbus_rr_picker.sv
// Combinational round-robin search: first set req bit strictly after 'last', wrapping.
// Pure logic with no state; the caller registers the result.
module rr_picker
  import regbus_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int OW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [OW-1:0]   last,
  output logic [OW-1:0]   pick,
  output logic            any
);

  logic [OW-1:0] w_idx;

  // Walk offsets from the farthest back to the nearest, so the nearest hit wins.
  always_comb begin
    pick  = '0;
    w_idx = '0;
    any   = |req;
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = OW'((int'(last) + k) % NREQ);
      if (req[w_idx]) begin
        pick = w_idx;
      end
    end
  end

endmodule

// File: rtl/regbus_arbiter.sv
// Round-robin owner of the shared tristate read bus; grant one cycle after request, TURN_CYCLES idle between owners.
// Optional forced release after MAX_HOLD grant cycles when REGBUS_HOLD_LIMIT_EN is defined.
module regbus_arbiter
  import regbus_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int TURN_CYCLES = 1,
  parameter int MAX_HOLD    = 8
) (
  input  logic                    clock,
  input  logic                    ctrl_reset,
  input  logic [NREQ-1:0]         req,
  output logic [NREQ-1:0]         grant,
  output logic [NREQ-1:0]         drive_en,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    bus_busy
);

  localparam int OW = owner_w(NREQ);

  if (NREQ < 2 || NREQ > NREQ_MAX || TURN_CYCLES < 1 || TURN_CYCLES > 7 ||
      MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_param
    $error("regbus_arbiter: parameter out of legal range");
  end

  state_t                r_state;
  logic [NREQ-1:0]       r_grant;
  logic [OW-1:0]         r_owner;
  logic [OW-1:0]         r_last;
  logic                  r_busy;
  logic [TURN_CNT_W-1:0] r_tcnt;

  logic [OW-1:0]         w_pick;
  logic                  w_any;
  logic                  w_preempt;
  logic                  w_release;

  rr_picker #(
    .NREQ (NREQ),
    .OW   (OW)
  ) u_picker (
    .req  (req),
    .last (r_last),
    .pick (w_pick),
    .any  (w_any)
  );

`ifdef REGBUS_HOLD_LIMIT_EN
  logic [HOLD_CNT_W-1:0] r_hold;

  // Only a competing requester can take the bus away; alone, the owner keeps it.
  assign w_preempt = (r_hold == HOLD_CNT_W'(MAX_HOLD)) && (|(req & ~r_grant));
`else
  assign w_preempt = 1'b0;
`endif

  assign w_release = ~req[r_owner] | w_preempt;

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_owner <= '0;
      r_last  <= OW'(NREQ - 1);
      r_busy  <= 1'b0;
      r_tcnt  <= '0;
`ifdef REGBUS_HOLD_LIMIT_EN
      r_hold  <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state <= ST_GRANT;
            r_grant <= {{(NREQ-1){1'b0}}, 1'b1} << w_pick;
            r_owner <= w_pick;
            r_last  <= w_pick;
            r_busy  <= 1'b1;
`ifdef REGBUS_HOLD_LIMIT_EN
            r_hold  <= HOLD_CNT_W'(1);
`endif
          end
        end
        ST_GRANT: begin
          if (w_release) begin
            r_state <= ST_TURN;
            r_grant <= '0;
            r_tcnt  <= '0;
`ifdef REGBUS_HOLD_LIMIT_EN
            r_hold  <= '0;
          end else if (r_hold != HOLD_CNT_W'(MAX_HOLD)) begin
            r_hold  <= r_hold + HOLD_CNT_W'(1);
`endif
          end
        end
        ST_TURN: begin
          // Pending requests are level-sensitive, so IDLE picks them up afterwards.
          if (r_tcnt == TURN_CNT_W'(TURN_CYCLES - 1)) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_tcnt  <= r_tcnt + TURN_CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign grant    = r_grant;
  assign drive_en = r_grant;
  assign owner    = r_owner;
  assign bus_busy = r_busy;

endmodule
